// File: rtl/rasterizer_pkg.sv
// Shared types for the rasterizer edge-test stage.
// Coordinates, edge values and the pixel/fragment bundles.
package rasterizer_pkg;

  localparam int COORD_W = 16;
  localparam int DIFF_W  = 17;
  localparam int PROD_W  = 34;
  localparam int EDGE_W  = 35;
  localparam int COLOR_W = 24;
  localparam int DEPTH_W = 16;

  localparam bit CULL_BACKFACE_DEFAULT = 1'b0;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [DIFF_W-1:0]  diff_t;
  typedef logic signed [PROD_W-1:0]  prod_t;
  typedef logic signed [EDGE_W-1:0]  edge_t;
  typedef logic [COLOR_W-1:0]        color_t;
  typedef logic [DEPTH_W-1:0]        depth_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t v0_x;
    coord_t v0_y;
    coord_t v1_x;
    coord_t v1_y;
    coord_t v2_x;
    coord_t v2_y;
    color_t v0_color;
    color_t v1_color;
    color_t v2_color;
    depth_t v0_depth;
    depth_t v1_depth;
    depth_t v2_depth;
  } pixel_state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    color_t v0_color;
    color_t v1_color;
    color_t v2_color;
    depth_t v0_depth;
    depth_t v1_depth;
    depth_t v2_depth;
  } attr_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    edge_t  e0;
    edge_t  e1;
    edge_t  e2;
    edge_t  area;
    color_t v0_color;
    color_t v1_color;
    color_t v2_color;
    depth_t v0_depth;
    depth_t v1_depth;
    depth_t v2_depth;
  } fragment_t;

  // Zero on an edge counts as inside for either winding.
  function automatic logic inside_test(
    edge_t area, edge_t e0, edge_t e1, edge_t e2, logic cull
  );
    logic r;
    logic a_zero;
    logic all_ge;
    logic all_le;
    r      = 1'b0;
    a_zero = (area == '0);
    all_ge = !e0[EDGE_W-1] && !e1[EDGE_W-1] && !e2[EDGE_W-1];
    all_le = (e0[EDGE_W-1] || e0 == '0)
          && (e1[EDGE_W-1] || e1 == '0)
          && (e2[EDGE_W-1] || e2 == '0);
    unique case (1'b1)
      (!area[EDGE_W-1] && !a_zero): r = all_ge;
      (area[EDGE_W-1]):             r = !cull && all_le;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/edge_eval.sv
// One edge function (xb-xa)*(y-ya) - (yb-ya)*(x-xa).
// Differences and products are registered; the final sum is combinational.
module edge_eval
  import rasterizer_pkg::*;
(
  input  logic   clk,
  input  logic   en,
  input  coord_t xa,
  input  coord_t ya,
  input  coord_t xb,
  input  coord_t yb,
  input  coord_t x,
  input  coord_t y,
  output edge_t  e
);

  diff_t dx;
  diff_t dy;
  diff_t qx;
  diff_t qy;
  prod_t p_a;
  prod_t p_b;

  always_ff @(posedge clk) begin
    if (en) begin
      dx  <= DIFF_W'(xb) - DIFF_W'(xa);
      dy  <= DIFF_W'(yb) - DIFF_W'(ya);
      qx  <= DIFF_W'(x) - DIFF_W'(xa);
      qy  <= DIFF_W'(y) - DIFF_W'(ya);
      p_a <= PROD_W'(dx) * PROD_W'(qy);
      p_b <= PROD_W'(dy) * PROD_W'(qx);
    end
  end

  assign e = EDGE_W'(p_a) - EDGE_W'(p_b);

endmodule

// File: rtl/edge_test.sv
// Triangle edge-test stage: three-deep valid/ready pipeline that
// emits inside fragments and turns rejected pixels into bubbles.
module edge_test
  import rasterizer_pkg::*;
#(
  parameter bit CULL_BACKFACE = CULL_BACKFACE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  pixel_state_t in_pixel,
  output logic         in_ready,
  output logic         out_valid,
  output fragment_t    out_frag,
  input  logic         out_ready,
  output logic [31:0]  frag_count,
  output logic [31:0]  drop_count
);

  logic  advance;
  logic  s1_valid;
  logic  s2_valid;
  logic  keep;
  attr_t s1_attr;
  attr_t s2_attr;
  edge_t e0;
  edge_t e1;
  edge_t e2;
  edge_t area;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  edge_eval u_e0 (
    .clk(clk), .en(advance),
    .xa(in_pixel.v1_x), .ya(in_pixel.v1_y),
    .xb(in_pixel.v2_x), .yb(in_pixel.v2_y),
    .x(in_pixel.x), .y(in_pixel.y), .e(e0)
  );

  edge_eval u_e1 (
    .clk(clk), .en(advance),
    .xa(in_pixel.v2_x), .ya(in_pixel.v2_y),
    .xb(in_pixel.v0_x), .yb(in_pixel.v0_y),
    .x(in_pixel.x), .y(in_pixel.y), .e(e1)
  );

  edge_eval u_e2 (
    .clk(clk), .en(advance),
    .xa(in_pixel.v0_x), .ya(in_pixel.v0_y),
    .xb(in_pixel.v1_x), .yb(in_pixel.v1_y),
    .x(in_pixel.x), .y(in_pixel.y), .e(e2)
  );

  // Signed area is edge v0->v1 sampled at the third vertex.
  edge_eval u_area (
    .clk(clk), .en(advance),
    .xa(in_pixel.v0_x), .ya(in_pixel.v0_y),
    .xb(in_pixel.v1_x), .yb(in_pixel.v1_y),
    .x(in_pixel.v2_x), .y(in_pixel.v2_y), .e(area)
  );

  assign keep = inside_test(area, e0, e1, e2, CULL_BACKFACE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      frag_count <= '0;
      drop_count <= '0;
    end else begin
      if (advance) begin
        s1_valid  <= in_valid;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid && keep;
        if (s2_valid && !keep)
          drop_count <= drop_count + 32'd1;
      end
      if (out_valid && out_ready)
        frag_count <= frag_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_attr <= '{
        x: in_pixel.x, y: in_pixel.y,
        v0_color: in_pixel.v0_color,
        v1_color: in_pixel.v1_color,
        v2_color: in_pixel.v2_color,
        v0_depth: in_pixel.v0_depth,
        v1_depth: in_pixel.v1_depth,
        v2_depth: in_pixel.v2_depth
      };
      s2_attr  <= s1_attr;
      out_frag <= '{
        x: s2_attr.x, y: s2_attr.y,
        e0: e0, e1: e1, e2: e2, area: area,
        v0_color: s2_attr.v0_color,
        v1_color: s2_attr.v1_color,
        v2_color: s2_attr.v2_color,
        v0_depth: s2_attr.v0_depth,
        v1_depth: s2_attr.v1_depth,
        v2_depth: s2_attr.v2_depth
      };
    end
  end

endmodule

// File: tb/tb_edge_test.sv
// Scoreboard bench for edge_test: directed cases plus random traffic,
// checked against a plain-arithmetic edge-function model.
module tb_edge_test;
  import rasterizer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic one = 1'b1;
  pixel_state_t in_pixel;

  logic in_ready, out_valid;
  logic in_ready_c, out_valid_c, in_valid_c;
  fragment_t out_frag, out_frag_c;
  logic [31:0] frag_count, drop_count;
  logic [31:0] frag_count_c, drop_count_c;

  always #5 clk = ~clk;

  // The culling instance sees exactly the pixels the first one accepts.
  assign in_valid_c = in_valid && in_ready;

  edge_test #(.CULL_BACKFACE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .out_valid(out_valid), .out_frag(out_frag), .out_ready(out_ready),
    .frag_count(frag_count), .drop_count(drop_count)
  );

  edge_test #(.CULL_BACKFACE(1'b1)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_c), .in_pixel(in_pixel), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .out_frag(out_frag_c), .out_ready(one),
    .frag_count(frag_count_c), .drop_count(drop_count_c)
  );

  typedef struct {
    fragment_t f;
    int        acc;
    bit        lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t em0, em1;
  fragment_t last0;
  fragment_t held;
  int nchk = 0, nfail = 0, cyc = 0;
  int kept0 = 0, kept1 = 0, drops0 = 0, drops1 = 0;
  bit chk_lat = 1'b1;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(string name, longint act, longint exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic show_fail(string name, fragment_t a, fragment_t e);
    $display("FAIL %s: got x=%0d y=%0d e=%0d/%0d/%0d a=%0d c0=%h d0=%h, expected x=%0d y=%0d e=%0d/%0d/%0d a=%0d c0=%h d0=%h",
      name, a.x, a.y, a.e0, a.e1, a.e2, a.area, a.v0_color, a.v0_depth,
      e.x, e.y, e.e0, e.e1, e.e2, e.area, e.v0_color, e.v0_depth);
  endtask

  function automatic longint ef(longint xa, longint ya, longint xb,
                                longint yb, longint x, longint y);
    return (xb - xa) * (y - ya) - (yb - ya) * (x - xa);
  endfunction

  function automatic bit covers(longint a, longint e0, longint e1,
                                longint e2, bit cull);
    if (a > 0) return e0 >= 0 && e1 >= 0 && e2 >= 0;
    if (a < 0) return !cull && e0 <= 0 && e1 <= 0 && e2 <= 0;
    return 1'b0;
  endfunction

  task automatic model(pixel_state_t p);
    longint x0, y0, x1, y1, x2, y2, px, py, a, e0, e1, e2;
    fragment_t f;
    exp_t e;
    x0 = p.v0_x; y0 = p.v0_y;
    x1 = p.v1_x; y1 = p.v1_y;
    x2 = p.v2_x; y2 = p.v2_y;
    px = p.x;    py = p.y;
    e0 = ef(x1, y1, x2, y2, px, py);
    e1 = ef(x2, y2, x0, y0, px, py);
    e2 = ef(x0, y0, x1, y1, px, py);
    a  = ef(x0, y0, x1, y1, x2, y2);
    f.x = p.x; f.y = p.y;
    f.e0 = e0[34:0]; f.e1 = e1[34:0];
    f.e2 = e2[34:0]; f.area = a[34:0];
    f.v0_color = p.v0_color; f.v1_color = p.v1_color;
    f.v2_color = p.v2_color;
    f.v0_depth = p.v0_depth; f.v1_depth = p.v1_depth;
    f.v2_depth = p.v2_depth;
    e.f = f; e.acc = cyc;
    if (covers(a, e0, e1, e2, 1'b0)) begin
      e.lat = chk_lat; q0.push_back(e); kept0++;
    end else drops0++;
    if (covers(a, e0, e1, e2, 1'b1)) begin
      e.lat = 1'b1; q1.push_back(e); kept1++;
    end else drops1++;
  endtask

  function automatic pixel_state_t mk(int x0, int y0, int x1, int y1,
                                      int x2, int y2, int px, int py);
    pixel_state_t p;
    p.v0_x = coord_t'(x0); p.v0_y = coord_t'(y0);
    p.v1_x = coord_t'(x1); p.v1_y = coord_t'(y1);
    p.v2_x = coord_t'(x2); p.v2_y = coord_t'(y2);
    p.x = coord_t'(px); p.y = coord_t'(py);
    p.v0_color = color_t'($urandom()); p.v1_color = color_t'($urandom());
    p.v2_color = color_t'($urandom());
    p.v0_depth = depth_t'($urandom()); p.v1_depth = depth_t'($urandom());
    p.v2_depth = depth_t'($urandom());
    return p;
  endfunction

  function automatic int rc(bit big);
    if (big) return int'(coord_t'($urandom()));
    return int'($urandom_range(0, 60)) - 30;
  endfunction

  // Call at posedge+1; returns at posedge+1 after the handshake.
  task automatic issue(pixel_state_t p);
    int n;
    n = 0;
    in_pixel = p;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 1000) begin
        chk("issue_timeout", 0, 1);
        break;
      end
    end
    if (in_ready) model(p);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      @(posedge clk); n++;
    end
    chk("drain_done", longint'(q0.size() + q1.size()), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    kept0 = 0; kept1 = 0; drops0 = 0; drops1 = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_valid_c", out_valid_c, 0);
    chk("rst_frag_count", frag_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_drop_count_c", drop_count_c, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_in_ready_c", in_ready_c, 1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        nchk++;
        if (q0.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_frag: got x=%0d y=%0d, expected none",
                   out_frag.x, out_frag.y);
        end else begin
          em0 = q0.pop_front();
          if (out_frag !== em0.f) begin
            nfail++;
            show_fail("frag", out_frag, em0.f);
          end
          if (em0.lat) chk("latency", cyc - em0.acc, 3);
          last0 = out_frag;
        end
      end
      if (out_valid_c) begin
        nchk++;
        if (q1.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_frag_c: got x=%0d y=%0d, expected none",
                   out_frag_c.x, out_frag_c.y);
        end else begin
          em1 = q1.pop_front();
          if (out_frag_c !== em1.f) begin
            nfail++;
            show_fail("frag_c", out_frag_c, em1.f);
          end
          chk("latency_c", cyc - em1.acc, 3);
        end
      end
    end
  end

  initial begin
    in_pixel = '0;
    @(posedge clk); #1;
    do_reset();

    issue(mk(0, 0, 10, 0, 0, 10, 2, 2));
    drain();
    chk("t1_e0", last0.e0, 60);
    chk("t1_e1", last0.e1, 20);
    chk("t1_e2", last0.e2, 20);
    chk("t1_area", last0.area, 100);
    chk("t1_frag_count", frag_count, 1);

    issue(mk(0, 0, 10, 0, 0, 10, 9, 9));
    drain();
    chk("t2_drop_count", drop_count, 1);
    chk("t2_frag_count", frag_count, 1);

    issue(mk(0, 0, 0, 10, 10, 0, 2, 2));
    drain();
    chk("t3_frag_count", frag_count, 2);
    chk("t3_frag_count_c", frag_count_c, 1);
    chk("t3_drop_count_c", drop_count_c, 2);

    issue(mk(0, 0, 5, 5, 10, 10, 5, 5));
    drain();
    chk("t4_drop_count", drop_count, 2);
    chk("t4_drop_count_c", drop_count_c, 3);

    do_reset();
    chk_lat = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(mk(0, 0, 100, 0, 0, 100, i + 1, i + 1));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          if (k == 0) begin
            chk("stall_out_valid", out_valid, 1);
            held = out_frag;
          end else begin
            nchk++;
            if (out_frag !== held) begin
              nfail++;
              show_fail("stall_hold", out_frag, held);
            end
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("t5_frag_count", frag_count, 8);
    chk("t5_drop_count", drop_count, 0);

    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++)
      issue(mk(0, 0, 100, 0, 0, 100, 10 + i, 5));
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    chk("t6_frag_count", frag_count, 0);
    chk("t6_frag_count_c", frag_count_c, 0);
    chk("t6_drop_count", drop_count, 0);

    chk_lat = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bit big;
      big = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(mk(rc(big), rc(big), rc(big), rc(big),
               rc(big), rc(big), rc(big), rc(big)));
    end
    drain();
    chk("rand_frag_count", frag_count, kept0);
    chk("rand_drop_count", drop_count, drops0);
    chk("rand_frag_count_c", frag_count_c, kept1);
    chk("rand_drop_count_c", drop_count_c, drops1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/edge_test.md
EDGE_TEST -- requirements
Module: edge_test

Interface
REQ-001 SHALL have parameter CULL_BACKFACE, default 0; when 1, pixels of triangles with negative signed area are dropped.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, upstream pixel valid.
REQ-005 SHALL have port in_pixel, input, pixel_state_t, candidate pixel (x, y, v0..v2, vN_color, vN_depth).
REQ-006 SHALL have port in_ready, output, 1, the stage accepts in_pixel this cycle.
REQ-007 SHALL have port out_valid, output, 1, out_frag holds an inside fragment.
REQ-008 SHALL have port out_frag, output, fragment_t, x, y, e0, e1, e2, area, colors, depths.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts out_frag.
REQ-010 SHALL have port frag_count, output, 32, count of fragments delivered (out_valid && out_ready).
REQ-011 SHALL have port drop_count, output, 32, count of accepted pixels rejected as outside, degenerate or culled.

Function
REQ-012 SHALL transfer on a port only when valid and ready are both high in the same cycle.
REQ-013 SHALL be a 3-stage pipeline: S1 coordinate differences, S2 products, S3 edge sums, inside test and output register.
REQ-014 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready = advance, combinational.
REQ-015 SHALL present an accepted inside pixel on out_valid exactly 3 cycles after acceptance when out_ready stays high.
REQ-016 SHALL, while advance is low, hold every stage register and out_frag stable.
REQ-017 SHALL compute with vertex and pixel coordinates as signed 16-bit integers, sample point (x, y).
REQ-018 SHALL compute Eab = (xb-xa)*(y-ya) - (yb-ya)*(x-xa) for edges e0 = E12, e1 = E20, e2 = E01, with 17-bit differences, 34-bit products and 35-bit signed sums; no truncation.
REQ-019 SHALL compute area = E01 evaluated at v2, at the same 35-bit signed width.
REQ-020 SHALL mark a pixel inside when area > 0 and e0, e1, e2 >= 0, or when area < 0 and e0, e1, e2 <= 0; edge value 0 counts as inside.
REQ-021 SHALL drop every pixel of a triangle with area == 0.
REQ-022 SHALL drop pixels with area < 0 when CULL_BACKFACE = 1.
REQ-023 SHALL turn a dropped pixel into a bubble at S3: out_valid stays low for it and the pipeline is not stalled.
REQ-024 SHALL pass x, y, colors and depths through unchanged alongside the edge values.
REQ-025 SHALL increment frag_count on each output handshake and drop_count on each S3 rejection that occurs while advance is high; both counters wrap from 0xFFFFFFFF to 0.
REQ-026 SHALL accept a new input in the same cycle the output is consumed, giving one pixel per clock under continuous flow.

Reset
REQ-027 SHALL, on rst high at any time, immediately clear all stage valid bits, out_valid, frag_count and drop_count to 0, discarding pixels in flight.
REQ-028 SHALL drive in_ready high from the first cycle after rst deasserts; datapath registers need no reset.

Structure
REQ-029 SHALL declare fragment_t, the 35-bit edge type edge_t, and CULL_BACKFACE default constants in rasterizer_pkg.
REQ-030 SHALL use one sub-module edge_eval (single edge function, 2 pipeline stages), instantiated three times, plus one instance for area.
REQ-031 SHALL be a pure valid/ready stage with no FSM beyond per-stage valid bits.

Verification
REQ-032 SHALL pass this test: triangle v0(0,0) v1(10,0) v2(0,10), pixel (2,2), out_ready=1 -> out_valid 3 cycles later with e0=60, e1=20, e2=20 and area=100.
REQ-033 SHALL pass this test: same triangle, pixel (9,9) -> no out_valid and drop_count +1.
REQ-034 SHALL pass this test: v0(0,0) v1(0,10) v2(10,0) (area -100), CULL_BACKFACE=0, pixel (2,2) -> fragment; with CULL_BACKFACE=1 -> dropped.
REQ-035 SHALL pass this test: collinear v0(0,0) v1(5,5) v2(10,10), pixel (5,5) -> dropped.
REQ-036 SHALL pass this test: 8 back-to-back inside pixels with out_ready low for cycles 4-7 -> out_frag held stable, in_ready low during the stall, all 8 delivered in order, frag_count=8.
REQ-037 SHALL pass this test: rst pulsed mid-stream with 3 pixels in flight -> out_valid=0 immediately, counters 0, none of those pixels emitted after reset.
